// File: rtl/tlc_pkg.sv
// Shared lamp codes, fault codes and the conflict-pair matrix for the traffic conflict monitor.
package tlc_pkg;

  localparam logic [2:0] LIGHT_GRN = 3'b001;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_RED = 3'b100;

  localparam logic [2:0] FLT_NONE      = 3'd0;
  localparam logic [2:0] FLT_CONFLICT  = 3'd1;
  localparam logic [2:0] FLT_ENC       = 3'd2;
  localparam logic [2:0] FLT_SEQ       = 3'd3;
  localparam logic [2:0] FLT_SHORT_YEL = 3'd4;
  localparam logic [2:0] FLT_WDOG      = 3'd5;

  localparam int LAMP_M1 = 0;
  localparam int LAMP_M2 = 1;
  localparam int LAMP_MT = 2;
  localparam int LAMP_S  = 3;

  // Row i, bit j set when lamps i and j may never be active together (symmetric).
  // Rows: S={M1,M2,MT}, MT={M2,S}, M2={MT,S}, M1={S}.
  localparam logic [3:0][3:0] CONFLICT_MAT = '{4'b0111, 4'b1010, 4'b1100, 4'b1000};

  function automatic logic is_lamp_code(input logic [2:0] code);
    return (code == LIGHT_GRN) || (code == LIGHT_YEL) || (code == LIGHT_RED);
  endfunction

  function automatic logic legal_step(input logic [2:0] prev, input logic [2:0] cur);
    return (prev == cur) ||
           (prev == LIGHT_RED && cur == LIGHT_GRN) ||
           (prev == LIGHT_GRN && cur == LIGHT_YEL) ||
           (prev == LIGHT_YEL && cur == LIGHT_RED);
  endfunction

  function automatic logic conflict_check(input logic [3:0] act);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (CONFLICT_MAT[i][j] && act[i] && act[j]) hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/tlc_lamp_checker.sv
// Per-lamp checker: remembers the last legal code, times yellow and filters bad encodings.
module tlc_lamp_checker
  import tlc_pkg::*;
#(
  parameter int MIN_YEL  = 3,
  parameter int ENC_FILT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
  input  logic       rebase,
  output logic       enc_bad,
  output logic       seq_err,
  output logic       yel_short,
  output logic       active
);

  localparam int YW = $clog2(MIN_YEL + 1);
  localparam int EW = $clog2(ENC_FILT + 1);

  logic [2:0]    prev;
  logic          hist_v;
  logic [YW-1:0] yel_cnt;
  logic [EW-1:0] enc_cnt;
  logic          valid;

  assign valid  = is_lamp_code(light);
  assign active = (light == LIGHT_GRN) || (light == LIGHT_YEL);

  // enc_cnt holds the number of preceding consecutive bad samples.
  assign enc_bad = !valid && (enc_cnt >= EW'(ENC_FILT - 1));

  // Invalid samples are left to the encoding filter; history only tracks legal codes.
  assign seq_err   = hist_v && valid && !legal_step(prev, light);
  assign yel_short = hist_v && (prev == LIGHT_YEL) && (light == LIGHT_RED) &&
                     (yel_cnt < YW'(MIN_YEL));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev    <= LIGHT_RED;
      hist_v  <= 1'b0;
      yel_cnt <= '0;
      enc_cnt <= '0;
    end else if (rebase) begin
      hist_v  <= 1'b0;
      yel_cnt <= '0;
      enc_cnt <= '0;
    end else begin
      if (valid) begin
        prev    <= light;
        hist_v  <= 1'b1;
        enc_cnt <= '0;
      end else if (enc_cnt != EW'(ENC_FILT)) begin
        enc_cnt <= enc_cnt + 1'b1;
      end
      if (light == LIGHT_YEL) begin
        if (yel_cnt != YW'(MIN_YEL)) yel_cnt <= yel_cnt + 1'b1;
      end else if (valid) begin
        yel_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Independent lamp-bus safety monitor: latches a fault code and requests flash-all-red.
// Optional TLC_SNAPSHOT_EN builds a register capturing the lamps at each fault latch.
module traffic_conflict_monitor
  import tlc_pkg::*;
#(
  parameter int MIN_YEL    = 3,
  parameter int WDOG       = 16,
  parameter int ENC_FILT   = 2,
  parameter int FLASH_HALF = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  light_M1,
  input  logic [2:0]  light_M2,
  input  logic [2:0]  light_MT,
  input  logic [2:0]  light_S,
  input  logic        clr,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic        flash_o,
  output logic [7:0]  fault_cnt,
  output logic [11:0] snap_lights
);

  localparam int WW = $clog2(WDOG + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);

  logic [2:0]    lamp [4];
  logic [3:0]    enc_bad, seq_err, yel_short, active, valid;
  logic [11:0]   lights_all, last_lights;
  logic [WW-1:0] wd_cnt;
  logic [FW-1:0] flash_cnt;
  logic          changed, wd_viol, conflict, viol, clear_ok;
  logic [2:0]    viol_code;

  assign lamp[LAMP_M1] = light_M1;
  assign lamp[LAMP_M2] = light_M2;
  assign lamp[LAMP_MT] = light_MT;
  assign lamp[LAMP_S]  = light_S;
  assign lights_all    = {light_M1, light_M2, light_MT, light_S};

  for (genvar g = 0; g < 4; g++) begin : g_lamp
    assign valid[g] = is_lamp_code(lamp[g]);
    tlc_lamp_checker #(.MIN_YEL(MIN_YEL), .ENC_FILT(ENC_FILT)) u_chk (
      .clk      (clk),
      .rst      (rst),
      .light    (lamp[g]),
      .rebase   (clear_ok),
      .enc_bad  (enc_bad[g]),
      .seq_err  (seq_err[g]),
      .yel_short(yel_short[g]),
      .active   (active[g])
    );
  end

  assign conflict = conflict_check(active);
  assign changed  = (lights_all != last_lights);
  assign wd_viol  = !changed && (wd_cnt >= WW'(WDOG - 1));

  always_comb begin
    viol_code = FLT_NONE;
    if (conflict)        viol_code = FLT_CONFLICT;
    else if (|enc_bad)   viol_code = FLT_ENC;
    else if (|seq_err)   viol_code = FLT_SEQ;
    else if (|yel_short) viol_code = FLT_SHORT_YEL;
    else if (wd_viol)    viol_code = FLT_WDOG;
  end

  assign viol = (viol_code != FLT_NONE);
  // A clear is refused while any lamp shows a non-one-hot code, even one still inside the filter.
  assign clear_ok = clr && fault && !viol && (&valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_lights <= '0;
      wd_cnt      <= '0;
    end else begin
      last_lights <= lights_all;
      if (clear_ok || changed) wd_cnt <= '0;
      else if (wd_cnt != WW'(WDOG)) wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
      flash_o    <= 1'b0;
      flash_cnt  <= '0;
      fault_cnt  <= '0;
    end else if (!fault) begin
      if (viol) begin
        fault      <= 1'b1;
        fault_code <= viol_code;
        flash_o    <= 1'b1;
        flash_cnt  <= '0;
        if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
      end
    end else if (clear_ok) begin
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
      flash_o    <= 1'b0;
      flash_cnt  <= '0;
    end else begin
      // A clear attempt that collides with a live violation reloads the code instead.
      if (clr && viol) fault_code <= viol_code;
      if (flash_cnt == FW'(FLASH_HALF - 1)) begin
        flash_o   <= ~flash_o;
        flash_cnt <= '0;
      end else begin
        flash_cnt <= flash_cnt + 1'b1;
      end
    end
  end

`ifdef TLC_SNAPSHOT_EN
  logic [11:0] snap_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) snap_q <= '0;
    else if (!fault && viol) snap_q <= lights_all;
  end

  assign snap_lights = snap_q;
`else
  assign snap_lights = 12'h000;
`endif

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor: legal laps, each fault class, clear and reset.
module tb_traffic_conflict_monitor;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] X = 3'b000;

  // Legal 6-phase cycle as {M1,M2,MT,S} with phase lengths.
  localparam logic [11:0] LAP [6] = '{
    {G, G, R, R}, {G, Y, R, R}, {G, R, G, R},
    {Y, R, Y, R}, {R, R, R, G}, {R, R, R, Y}
  };
  localparam int LAP_LEN [6] = '{8, 3, 6, 3, 4, 3};

  logic        clk;
  logic        rst;
  logic [2:0]  light_M1, light_M2, light_MT, light_S;
  logic        clr;
  logic        fault;
  logic [2:0]  fault_code;
  logic        flash_o;
  logic [7:0]  fault_cnt;
  logic [11:0] snap_lights;

  int tests_run;
  int tests_failed;
  logic [2:0] exp_q[$];
  logic [11:0] snap_exp;

  traffic_conflict_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .light_M1   (light_M1),
    .light_M2   (light_M2),
    .light_MT   (light_MT),
    .light_S    (light_S),
    .clr        (clr),
    .fault      (fault),
    .fault_code (fault_code),
    .flash_o    (flash_o),
    .fault_cnt  (fault_cnt),
    .snap_lights(snap_lights)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic set_all(input logic [11:0] v);
    {light_M1, light_M2, light_MT, light_S} = v;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_lap();
    for (int p = 0; p < 6; p++) begin
      set_all(LAP[p]);
      tick(LAP_LEN[p]);
    end
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  // Scoreboard
  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_latch(input logic [7:0] cnt_exp);
    logic [2:0] code_exp;
    code_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd0;
    check("latch_fault", {11'd0, fault}, 12'd1);
    check("latch_code", {9'd0, fault_code}, {9'd0, code_exp});
    check("latch_cnt", {4'd0, fault_cnt}, {4'd0, cnt_exp});
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_fault"}, {11'd0, fault}, 12'd0);
    check({tag, "_code"}, {9'd0, fault_code}, 12'd0);
    check({tag, "_flash"}, {11'd0, flash_o}, 12'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b0;
    clr = 1'b0;
    set_all(LAP[0]);
    tick(2);
    check_clear("reset");
    check("reset_cnt", {4'd0, fault_cnt}, 12'd0);
    check("reset_snap", snap_lights, 12'd0);
    rst = 1'b1;

    // 1: three legal laps
    for (int lap = 0; lap < 3; lap++) begin
      run_lap();
      check("lap_fault", {11'd0, fault}, 12'd0);
      check("lap_flash", {11'd0, flash_o}, 12'd0);
    end
    check("lap_cnt", {4'd0, fault_cnt}, 12'd0);

    // 2: M2 and MT green together
    set_all(LAP[0]);
    tick(2);
    set_all({G, G, G, R});
    exp_q.push_back(3'd1);
    tick(1);
    check_latch(8'd1);
    check("flash_first", {11'd0, flash_o}, 12'd1);
    tick(3);
    check("flash_hold", {11'd0, flash_o}, 12'd1);
    tick(1);
    check("flash_toggle", {11'd0, flash_o}, 12'd0);
    tick(4);
    check("flash_toggle2", {11'd0, flash_o}, 12'd1);
    set_all(LAP[0]);
    tick(2);
    do_clear();
    check_clear("clr_conflict");

    // 3: M1 green straight to red, then encoding glitches
    tick(1);
    set_all({R, G, R, R});
    exp_q.push_back(3'd3);
    tick(1);
    check_latch(8'd2);
    tick(1);
    do_clear();
    check_clear("clr_seq");
    tick(1);
    set_all({X, G, R, R});
    tick(1);
    check("enc_1cyc", {11'd0, fault}, 12'd0);
    set_all({R, G, R, R});
    tick(2);
    check("enc_recover", {11'd0, fault}, 12'd0);
    set_all({X, G, R, R});
    exp_q.push_back(3'd2);
    tick(1);
    check("enc_filter", {11'd0, fault}, 12'd0);
    tick(1);
    check_latch(8'd3);
    set_all({R, G, R, R});
    tick(1);
    do_clear();
    check_clear("clr_enc");

    // 4: MT yellow for only 2 cycles
    tick(1);
    set_all({R, Y, R, R}); tick(3);
    set_all({R, R, R, R}); tick(1);
    set_all({G, R, G, R}); tick(2);
    set_all({G, R, Y, R}); tick(2);
    check("short_yel_pre", {11'd0, fault}, 12'd0);
    set_all({G, R, R, R});
    exp_q.push_back(3'd4);
    tick(1);
    check_latch(8'd4);
    do_clear();
    check_clear("clr_short");
    set_all({Y, R, R, R}); tick(3);
    set_all({R, R, R, G}); tick(4);
    set_all({R, R, R, Y}); tick(3);
    run_lap();
    check("post_clr_fault", {11'd0, fault}, 12'd0);
    check("post_clr_flash", {11'd0, flash_o}, 12'd0);

    // 5: frozen lamps trip the watchdog, then clr colliding with a conflict
    set_all(LAP[0]);
    tick(16);
    check("wdog_pre", {11'd0, fault}, 12'd0);
    exp_q.push_back(3'd5);
    tick(1);
    check_latch(8'd5);
    set_all({G, G, G, R});
    do_clear();
    check("clr_conflict_fault", {11'd0, fault}, 12'd1);
    check("clr_conflict_code", {9'd0, fault_code}, 12'd1);
    check("clr_conflict_cnt", {4'd0, fault_cnt}, 12'd5);

    // 6: snapshot, then asynchronous reset mid-fault
`ifdef TLC_SNAPSHOT_EN
    snap_exp = {G, G, R, R};
`else
    snap_exp = 12'h000;
`endif
    check("snap", snap_lights, snap_exp);
    rst = 1'b0;
    #2;
    check_clear("async_rst");
    check("async_rst_cnt", {4'd0, fault_cnt}, 12'd0);
    check("async_rst_snap", snap_lights, 12'd0);

    check("exp_q_drained", exp_q.size(), 12'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
